// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map and status layout shared by the GPIO/UART peripheral
package gpio_pkg;

    localparam logic [2:0] REG_OUT        = 3'd0;
    localparam logic [2:0] REG_OUT_SET    = 3'd1;
    localparam logic [2:0] REG_OUT_CLR    = 3'd2;
    localparam logic [2:0] REG_IN         = 3'd3;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd4;
    localparam logic [2:0] REG_IRQ_ENABLE = 3'd5;
    localparam logic [2:0] REG_RX_DATA    = 3'd6;
    localparam logic [2:0] REG_RX_STATUS  = 3'd7;

    localparam logic [2:0] ACC_STATE = 3'd6;

    localparam int RX_EMPTY_BIT  = 0;
    localparam int RX_FULL_BIT   = 1;
    localparam int RX_OVF_BIT    = 2;
    localparam int RX_COUNT_LSB  = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead FIFO; a pop frees room for a same-cycle push when full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_evt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign do_pop       = pop && !empty;
    assign do_push      = push && (!full || do_pop);
    assign overflow_evt = push && full && !do_pop;
    assign dout         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/gpio_uart_ctrl.sv
// rtl/gpio_uart_ctrl.sv - memory-mapped output/input banks with edge IRQs and a UART RX FIFO
module gpio_uart_ctrl
    import gpio_pkg::*;
#(
    parameter int NUM_OUT  = 4,
    parameter int NUM_IN   = 4,
    parameter int RX_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         state,
    input  logic               enabled,
    input  logic               load_enable,
    input  logic               store_enable,
    input  logic [31:0]        address,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    input  logic [NUM_IN-1:0]  gpio_in,
    output logic [NUM_OUT-1:0] gpio_out,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    output logic               irq
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic              acc, wr, rd;
    logic [2:0]        idx;
    logic [NUM_IN-1:0] sync1, sync2, hist, rise, w1c;
    logic [NUM_IN-1:0] irq_status, irq_enable;
    logic              overflow;
    logic              ovf_clr;
    logic [7:0]        fifo_dout;
    logic              fifo_empty, fifo_full, ovf_evt;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       count32;
    logic [7:0]        count8;
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign acc     = enabled && (state == ACC_STATE);
    assign wr      = acc && store_enable;
    assign rd      = acc && load_enable && !store_enable;
    assign idx     = address[4:2];
    assign rise    = sync2 & ~hist;
    assign w1c     = (wr && idx == REG_IRQ_STATUS) ? data_in[NUM_IN-1:0] : '0;
    assign ovf_clr = wr && (idx == REG_RX_STATUS);
    assign count32 = 32'(fifo_count);
    assign count8  = (count32 > 32'd255) ? 8'hFF : count32[7:0];
    assign unused_bits = ^{address[31:5], address[1:0], data_in};

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (rx_valid),
        .pop          (rd && idx == REG_RX_DATA),
        .din          (rx_byte),
        .dout         (fifo_dout),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .count        (fifo_count),
        .overflow_evt (ovf_evt)
    );

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_OUT:        rd_data = 32'(gpio_out);
            REG_IN:         rd_data = 32'(sync2);
            REG_IRQ_STATUS: rd_data = 32'(irq_status);
            REG_IRQ_ENABLE: rd_data = 32'(irq_enable);
            REG_RX_DATA:    rd_data = fifo_empty ? 32'd0 : 32'(fifo_dout);
            REG_RX_STATUS: begin
                rd_data[RX_EMPTY_BIT]              = fifo_empty;
                rd_data[RX_FULL_BIT]               = fifo_full;
                rd_data[RX_OVF_BIT]                = overflow;
                rd_data[RX_COUNT_LSB +: 8]         = count8;
            end
            default:        rd_data = '0;
        endcase
    end

    // New edges and new overflow events take priority over same-cycle clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out   <= '0;
            data_out   <= '0;
            irq        <= 1'b0;
            sync1      <= '0;
            sync2      <= '0;
            hist       <= '0;
            irq_status <= '0;
            irq_enable <= '0;
            overflow   <= 1'b0;
        end else begin
            sync1      <= gpio_in;
            sync2      <= sync1;
            hist       <= sync2;
            irq_status <= (irq_status & ~w1c) | rise;
            irq        <= |(irq_status & irq_enable);
            overflow   <= ovf_evt | (overflow & ~ovf_clr);
            if (wr) begin
                case (idx)
                    REG_OUT:        gpio_out   <= data_in[NUM_OUT-1:0];
                    REG_OUT_SET:    gpio_out   <= gpio_out | data_in[NUM_OUT-1:0];
                    REG_OUT_CLR:    gpio_out   <= gpio_out & ~data_in[NUM_OUT-1:0];
                    REG_IRQ_ENABLE: irq_enable <= data_in[NUM_IN-1:0];
                    default: ;
                endcase
            end
            if (rd) begin
                data_out <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_gpio_uart_ctrl.sv
// tb/tb_gpio_uart_ctrl.sv - directed bench for gpio_uart_ctrl (NUM_OUT=8, NUM_IN=4, RX_DEPTH=8)
module tb_gpio_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic        enabled, load_enable, store_enable;
    logic [31:0] address, data_in;
    logic [31:0] data_out;
    logic [3:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_uart_ctrl #(.NUM_OUT(8), .NUM_IN(4), .RX_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .enabled      (enabled),
        .load_enable  (load_enable),
        .store_enable (store_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .irq          (irq)
    );

    // Called at a falling edge; the following rising edge performs the cycle.
    task automatic bus(input logic [2:0] st, input logic en, input logic we, input logic re,
                       input logic [2:0] idx, input logic [31:0] d, input logic pv, input logic [7:0] pb);
        state = st; enabled = en; store_enable = we; load_enable = re;
        address = 32'h8000_0000 | {27'd0, idx, 2'b00};
        data_in = d; rx_valid = pv; rx_byte = pb;
        @(negedge clk);
        state = 3'd0; enabled = 1'b0; store_enable = 1'b0; load_enable = 1'b0;
        data_in = 32'd0; rx_valid = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        bus(3'd6, 1'b1, 1'b1, 1'b0, idx, d, 1'b0, 8'd0);
    endtask

    task automatic rd(input logic [2:0] idx);
        bus(3'd6, 1'b1, 1'b0, 1'b1, idx, 32'd0, 1'b0, 8'd0);
    endtask

    task automatic push(input logic [7:0] b);
        bus(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1, b);
    endtask

    task automatic test_reset;
        total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL rst_gpio_out got=%h exp=00", gpio_out); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL rst_data_out got=%h exp=0", data_out); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
        @(negedge clk); rst = 1'b0;
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0001) begin bad++; $display("FAIL rst_rx_status got=%h exp=00000001", data_out); end
        rd(3'd4);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL rst_irq_status got=%h exp=0", data_out); end
    endtask

    task automatic test_out;
        wr(3'd0, 32'h0000_000F);
        wr(3'd2, 32'h0000_0005);
        wr(3'd1, 32'h0000_0010);
        total++; if (gpio_out !== 8'h1A) begin bad++; $display("FAIL out_pins got=%h exp=1a", gpio_out); end
        rd(3'd0);
        total++; if (data_out !== 32'h0000_001A) begin bad++; $display("FAIL out_read got=%h exp=0000001a", data_out); end
        rd(3'd1);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL out_set_read got=%h exp=0", data_out); end
        wr(3'd0, 32'hFFFF_FF3C);
        total++; if (gpio_out !== 8'h3C) begin bad++; $display("FAIL out_upper_ignored got=%h exp=3c", gpio_out); end
    endtask

    task automatic test_irq;
        wr(3'd5, 32'h1);
        gpio_in = 4'b0001;
        @(negedge clk); @(negedge clk); @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
        rd(3'd4);
        total++; if (data_out !== 32'h1) begin bad++; $display("FAIL irq_status got=%h exp=1", data_out); end
        rd(3'd3);
        total++; if (data_out !== 32'h1) begin bad++; $display("FAIL in_read got=%h exp=1", data_out); end
        wr(3'd4, 32'h1);
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b exp=0", irq); end
        gpio_in = 4'b0000;
        repeat (4) @(negedge clk);
        gpio_in = 4'b0001;
        @(negedge clk); @(negedge clk);
        wr(3'd4, 32'h1);
        rd(3'd4);
        total++; if (data_out !== 32'h1) begin bad++; $display("FAIL irq_set_wins got=%h exp=1", data_out); end
    endtask

    task automatic test_fifo;
        push(8'h41);
        push(8'h42);
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0200) begin bad++; $display("FAIL rx_status_two got=%h exp=00000200", data_out); end
        rd(3'd6);
        total++; if (data_out !== 32'h41) begin bad++; $display("FAIL rx_data0 got=%h exp=41", data_out); end
        rd(3'd6);
        total++; if (data_out !== 32'h42) begin bad++; $display("FAIL rx_data1 got=%h exp=42", data_out); end
        rd(3'd6);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL rx_data_empty got=%h exp=0", data_out); end
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0001) begin bad++; $display("FAIL rx_status_empty got=%h exp=00000001", data_out); end
        bus(3'd6, 1'b1, 1'b0, 1'b1, 3'd6, 32'd0, 1'b1, 8'h55);
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL rx_pushpop_empty got=%h exp=0", data_out); end
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0100) begin bad++; $display("FAIL rx_pushpop_count got=%h exp=00000100", data_out); end
        rd(3'd6);
        total++; if (data_out !== 32'h55) begin bad++; $display("FAIL rx_pushpop_byte got=%h exp=55", data_out); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_b;
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0806) begin bad++; $display("FAIL ovf_status got=%h exp=00000806", data_out); end
        wr(3'd7, 32'h0);
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0802) begin bad++; $display("FAIL ovf_clear got=%h exp=00000802", data_out); end
        bus(3'd6, 1'b1, 1'b0, 1'b1, 3'd6, 32'd0, 1'b1, 8'h99);
        total++; if (data_out !== 32'h10) begin bad++; $display("FAIL full_pushpop_head got=%h exp=10", data_out); end
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0802) begin bad++; $display("FAIL full_pushpop_status got=%h exp=00000802", data_out); end
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? 8'h11 + 8'(i) : 8'h99;
            rd(3'd6);
            total++; if (data_out !== 32'(exp_b)) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, data_out, exp_b); end
        end
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0001) begin bad++; $display("FAIL drain_status got=%h exp=00000001", data_out); end
    endtask

    task automatic test_gating;
        wr(3'd0, 32'h5A);
        push(8'h77);
        bus(3'd5, 1'b1, 1'b1, 1'b0, 3'd0, 32'hFF, 1'b0, 8'd0);
        total++; if (gpio_out !== 8'h5A) begin bad++; $display("FAIL gate_state_wr got=%h exp=5a", gpio_out); end
        bus(3'd6, 1'b0, 1'b1, 1'b0, 3'd1, 32'hFF, 1'b0, 8'd0);
        total++; if (gpio_out !== 8'h5A) begin bad++; $display("FAIL gate_en_wr got=%h exp=5a", gpio_out); end
        bus(3'd2, 1'b1, 1'b0, 1'b1, 3'd6, 32'd0, 1'b0, 8'd0);
        total++; if (data_out !== 32'h1) begin bad++; $display("FAIL gate_state_rd got=%h exp=1", data_out); end
        bus(3'd6, 1'b0, 1'b0, 1'b1, 3'd6, 32'd0, 1'b0, 8'd0);
        total++; if (data_out !== 32'h1) begin bad++; $display("FAIL gate_en_rd got=%h exp=1", data_out); end
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0100) begin bad++; $display("FAIL gate_no_pop got=%h exp=00000100", data_out); end
    endtask

    task automatic test_reset_mid;
        wr(3'd0, 32'hFF);
        push(8'hAA);
        rd(3'd0);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_rst_irq got=%b exp=1", irq); end
        rx_valid = 1'b1; rx_byte = 8'hBB;
        #2 rst = 1'b1;
        #1;
        total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL async_gpio_out got=%h exp=00", gpio_out); end
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL async_data_out got=%h exp=0", data_out); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_irq got=%b exp=0", irq); end
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(3'd7);
        total++; if (data_out !== 32'h0000_0001) begin bad++; $display("FAIL post_rst_status got=%h exp=00000001", data_out); end
    endtask

    initial begin
        rst = 1'b1; state = 3'd0; enabled = 1'b0; load_enable = 1'b0; store_enable = 1'b0;
        address = 32'd0; data_in = 32'd0; gpio_in = 4'd0; rx_byte = 8'd0; rx_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        test_reset;
        test_out;
        test_irq;
        test_fifo;
        test_overflow;
        test_gating;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
